imem_loader: RTL
================

Name: imem_loader

Overview:
- Writer side of the instruction memory; the processor core is the reader.
- Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and writes them to instruction memory at sequential word addresses.
- Holds the core in reset until the program image is fully loaded, then releases it.
- Sits between a host byte source (UART/JTAG bridge) and the instruction-memory write port plus the core's active-low reset.

Parameters:
- DEPTH_WORDS, 64, instruction memory capacity in 32-bit words; maximum legal image length.
- BASE_ADDR, 32'h0000_0000, byte address of the first written word; must be word aligned.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begins a load (accepted in IDLE and DONE only)
- in_valid  in  1  byte source has data
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte this cycle (transfer = in_valid & in_ready)
- imem_we  out  1  instruction memory write enable, one-cycle pulse per word
- imem_addr  out  32  byte address of the write, word aligned
- imem_wdata  out  32  word to write
- core_reset_n  out  1  active-low reset to the core; 0 unless state is DONE
- done  out  1  image loaded; core running
- error  out  1  load aborted; sticky until next start or reset

Behaviour:
- Reset, asynchronous: state=IDLE. Outputs: in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, done=0, error=0, core_reset_n=0. Internal byte index, word count and word counter cleared.
- Stream format:
  - 4-byte length N, little-endian.
  - Then N words, each 4 bytes, little-endian (first byte goes to bits [7:0]).
- States: IDLE, LEN, DATA, DONE, ERR.
  - IDLE: in_ready=0. start -> LEN.
  - LEN: in_ready=1. Collects 4 bytes into N.
    - After the 4th byte, if N==0 -> DONE.
    - If N>DEPTH_WORDS -> ERR.
    - Otherwise -> DATA.
  - DATA: in_ready=1. Each 4th byte completes a word.
    - Cycle after the completing transfer: imem_we=1, imem_wdata=assembled word, imem_addr=BASE_ADDR+4*k for word k (0-based).
    - in_ready stays 1 during the write cycle; the byte path is independent of the write register, so one byte per cycle is sustained.
    - Transition to DONE happens the same cycle the Nth word's imem_we is high; core_reset_n=1 from the following cycle.
  - DONE: done=1, core_reset_n=1, in_ready=0. start -> LEN; core_reset_n=0 and done=0 from the next cycle.
  - ERR: error=1, in_ready=0, core_reset_n=0. start -> LEN and clears error.
- start in LEN or DATA is ignored.
- in_valid=0 stalls with no state change. Byte index persists across stall cycles.
- Address arithmetic is 32-bit modulo. imem_addr holds its last value when imem_we=0.
- reset asserted mid-load: immediate return to IDLE, core_reset_n=0. A partially written image is not erased.

Optional Feature:
- IMEM_LOADER_CHECKSUM_EN
- When defined:
  - After the N words, one extra 4-byte little-endian checksum word is expected.
  - Checksum = 32-bit modulo sum of all N data words.
  - Match -> DONE. Mismatch -> ERR.
  - For N==0 the checksum word is still required and must be 0.
  - Extra state CSUM between DATA and DONE, with in_ready=1.
- When undefined: no checksum; DATA goes directly to DONE as above.

Decomposition:
- Shared package holds:
  - state enum (IDLE, LEN, DATA, CSUM, DONE, ERR)
  - BYTES_PER_WORD=4
  - WORD_W=32
- One sub-module, byte_assembler: shifts 4 bytes into a 32-bit little-endian word, outputs a word_valid pulse. It is reused for the length field, the data words and the checksum.

Test Plan:
- Reset then start, stream 02 00 00 00, 13 00 00 00, 93 00 10 00 -> imem_we pulses at addr 0 with data 0x00000013, then addr 4 with data 0x00100093; done=1; core_reset_n rises the cycle after the second write.
- Same stream with in_valid toggled every other cycle -> identical writes and data; no byte lost or duplicated.
- Length 00 00 00 00 -> no imem_we pulses; done=1 right after the 4th length byte.
- Length 41 00 00 00 (65 > DEPTH_WORDS=64) -> error=1, in_ready=0, core_reset_n=0; then start plus a valid stream -> error clears and the load completes.
- reset asserted after 5 data bytes of a 2-word load -> all outputs return to reset values the same cycle; the following start reloads from addr BASE_ADDR.
- With IMEM_LOADER_CHECKSUM_EN: 2-word image with checksum A6 00 10 00 (0x001000A6) -> done=1. With checksum 00 00 00 00 -> error=1, core_reset_n stays 0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Optional checksum trailer is enabled by defining IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready handshake between the host byte source and the loader.
interface imem_loader_if;

  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/imem_loader_byte_assembler.sv
// Collects BYTES_PER_WORD bytes into a little-endian word. The word and its
// valid pulse are presented combinationally on the transfer of the last byte,
// so the caller can act on it at the same clock edge.
module imem_loader_byte_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  logic [IDX_W-1:0]  idx;
  logic [WORD_W-9:0] low;

  // Completing byte lands in the top lane; earlier bytes are already shifted down.
  always_comb begin
    word_valid = byte_valid && (idx == IDX_W'(BYTES_PER_WORD - 1));
    word       = {byte_data, low};
  end

  // Byte index and partial-word shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
      low <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (byte_valid) begin
      low <= {byte_data, low[WORD_W-9:8]};
      idx <= word_valid ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a length-prefixed little-endian byte
// image, writes it to sequential word addresses and holds the core in reset
// until the image is complete. Define IMEM_LOADER_CHECKSUM_EN to require a
// trailing 32-bit sum-of-words checksum before the core is released.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned       DEPTH_WORDS = 64,
  parameter logic [WORD_W-1:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  imem_loader_if.slave      in_if,
  output logic              imem_we,
  output logic [WORD_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              core_reset_n,
  output logic              done,
  output logic              error
);

  state_t            state, state_next;
  logic              xfer;
  logic              start_load;
  logic              word_valid;
  logic              last_word;
  logic [WORD_W-1:0] word;
  logic [WORD_W-1:0] len_q;
  logic [WORD_W-1:0] wr_count;
  logic [WORD_W-1:0] next_addr;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] sum_q;
`endif

  assign xfer = in_if.in_valid && in_if.in_ready;

  imem_loader_byte_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_load),
    .byte_valid (xfer),
    .byte_data  (in_if.in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_next   = state;
    in_if.in_ready = 1'b0;
    done         = 1'b0;
    error        = 1'b0;
    last_word    = (wr_count == len_q - 1'b1);
    case (state)
      IDLE: if (start) state_next = LEN;
      LEN: begin
        in_if.in_ready = 1'b1;
        if (word_valid) begin
          if (word == '0)
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_next = CSUM;
`else
            state_next = DONE;
`endif
          else if (word > WORD_W'(DEPTH_WORDS)) state_next = ERR;
          else                                  state_next = DATA;
        end
      end
      DATA: begin
        in_if.in_ready = 1'b1;
        if (word_valid && last_word)
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_next = CSUM;
`else
          state_next = DONE;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      // sum_q already includes the final data word by the time CSUM is entered.
      CSUM: begin
        in_if.in_ready = 1'b1;
        if (word_valid) state_next = (word == sum_q) ? DONE : ERR;
      end
`endif
      DONE: begin
        done = 1'b1;
        if (start) state_next = LEN;
      end
      ERR: begin
        error = 1'b1;
        if (start) state_next = LEN;
      end
      default: state_next = IDLE;
    endcase
    start_load = (state_next == LEN) && (state != LEN);
  end

  // Length capture, write port, address/count tracking and core reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q        <= '0;
      wr_count     <= '0;
      next_addr    <= BASE_ADDR;
      imem_we      <= 1'b0;
      imem_addr    <= BASE_ADDR;
      imem_wdata   <= '0;
      core_reset_n <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      // Registered so release lags the final write by one cycle and drops
      // together with done when a new load starts.
      core_reset_n <= (state == DONE) && (state_next == DONE);
      if (start_load) begin
        wr_count  <= '0;
        next_addr <= BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_q     <= '0;
`endif
      end
      if (state == LEN && word_valid) len_q <= word;
      if (state == DATA && word_valid) begin
        imem_we    <= 1'b1;
        imem_wdata <= word;
        imem_addr  <= next_addr;
        next_addr  <= next_addr + WORD_W'(BYTES_PER_WORD);
        wr_count   <= wr_count + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_q      <= sum_q + word;
`endif
      end
    end
  end

endmodule
